snn_frame_ctrl: RTL and testbench

- Parametrised host-side sequencer for the SNN accelerator.
- Receives a frame of NUM_BYTES UART bytes and unpacks each byte into 8 single-bit writes to the 1-bit-wide input RAM.
- When the frame is complete it pulses core start, waits for core done, latches the classified digit and transmits it back as one ASCII byte via the UART transmitter.
- Sits between uart_rx/uart_tx, the input RAM and snn_core at top level; replaces ad-hoc top-level FSM glue.

---
 rtl/snn_ctrl_pkg.sv | 22 ++
 rtl/snn_byte_unpack.sv | 35 +++
 rtl/snn_frame_ctrl.sv | 143 ++++++++++++++
 tb/tb_snn_frame_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_ctrl_pkg.sv
// rtl/snn_ctrl_pkg.sv - shared types and constants for the SNN frame sequencer
package snn_ctrl_pkg;

  typedef enum logic [2:0] {
    RX,
    UNPACK,
    START,
    WAIT_CORE,
    TX_REQ,
    TX_HOLD,
    TX_WAIT
  } state_t;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam int         BITS_PER_BYTE = 8;

  // Result is at most 7 bits, so the ASCII offset never carries past bit 7.
  function automatic logic [7:0] digit_to_ascii(input logic [6:0] digit);
    return ASCII_ZERO + {1'b0, digit};
  endfunction

endpackage

// File: rtl/snn_byte_unpack.sv
// rtl/snn_byte_unpack.sv - byte shift register emitting one bit per shift, LSB first
module snn_byte_unpack
  import snn_ctrl_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load,
  input  logic [BITS_PER_BYTE-1:0]         data,
  input  logic                             shift_en,
  output logic                             bit_out,
  output logic                             last_bit,
  output logic [$clog2(BITS_PER_BYTE)-1:0] bit_cnt
);

  localparam int CNT_W = $clog2(BITS_PER_BYTE);

  logic [BITS_PER_BYTE-1:0] shift_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= data;
      bit_cnt   <= '0;
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[BITS_PER_BYTE-1:1]};
      bit_cnt   <= bit_cnt + CNT_W'(1);
    end
  end

  assign bit_out  = shift_reg[0];
  assign last_bit = (bit_cnt == CNT_W'(BITS_PER_BYTE - 1));

endmodule

// File: rtl/snn_frame_ctrl.sv
// rtl/snn_frame_ctrl.sv - UART frame to input-RAM sequencer, core handshake and ASCII result reply
// Optional inter-byte idle timeout enabled by defining SNN_RX_TIMEOUT_EN.
module snn_frame_ctrl
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_BYTES   = 98,
  parameter int ADDR_W      = 10,
  parameter int RESULT_W    = 4,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_rdy,
  input  logic [7:0]          rx_data,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_d,
  output logic                core_start,
  input  logic                core_done,
  input  logic [RESULT_W-1:0] core_digit,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  input  logic                tx_rdy,
  output logic [RESULT_W-1:0] result,
  output logic                busy,
  output logic                overrun,
  output logic                frame_err
);

  localparam int BYTE_W = ADDR_W - 3;

  if ((2 ** ADDR_W) < NUM_BYTES * BITS_PER_BYTE) begin : g_bad_addr_w
    $error("ADDR_W too small for NUM_BYTES");
  end
  if (RESULT_W > 7 || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("RESULT_W must be <= 7 and TIMEOUT_CYC >= 2");
  end

  state_t              state;
  logic [BYTE_W-1:0]   byte_cnt;
  logic [ADDR_W-1:0]   addr_hold;
  logic [ADDR_W-1:0]   cur_addr;
  logic [2:0]          bit_cnt;
  logic                bit_out;
  logic                last_bit;
  logic                timeout_hit;

  snn_byte_unpack u_unpack (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     ((state == RX) && rx_rdy),
    .data     (rx_data),
    .shift_en (state == UNPACK),
    .bit_out  (bit_out),
    .last_bit (last_bit),
    .bit_cnt  (bit_cnt)
  );

  assign cur_addr   = {byte_cnt, bit_cnt};
  assign ram_we     = (state == UNPACK);
  assign ram_d      = ram_we & bit_out;
  assign ram_addr   = ram_we ? cur_addr : addr_hold;
  assign core_start = (state == START);
  assign tx_start   = (state == TX_REQ) && tx_rdy;
  assign busy       = !((state == RX) && (byte_cnt == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX;
      byte_cnt  <= '0;
      addr_hold <= '0;
      result    <= '0;
      tx_data   <= ASCII_ZERO;
      overrun   <= 1'b0;
    end else begin
      // Any byte arriving outside RX is lost; the TX_WAIT exit below clears this.
      if (rx_rdy && (state != RX))
        overrun <= 1'b1;

      case (state)
        RX: begin
          if (rx_rdy)
            state <= UNPACK;
          else if (timeout_hit)
            byte_cnt <= '0;
        end
        UNPACK: begin
          addr_hold <= cur_addr;
          if (last_bit) begin
            byte_cnt <= byte_cnt + BYTE_W'(1);
            state    <= (byte_cnt == BYTE_W'(NUM_BYTES - 1)) ? START : RX;
          end
        end
        START: state <= WAIT_CORE;
        WAIT_CORE: begin
          if (core_done) begin
            result  <= core_digit;
            tx_data <= digit_to_ascii(7'(core_digit));
            state   <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (tx_rdy)
            state <= TX_HOLD;
        end
        TX_HOLD: state <= TX_WAIT;
        TX_WAIT: begin
          if (tx_rdy) begin
            byte_cnt <= '0;
            overrun  <= 1'b0;
            state    <= RX;
          end
        end
        default: state <= RX;
      endcase
    end
  end

`ifdef SNN_RX_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // A byte arriving in the same cycle as expiry keeps the partial frame alive.
  assign timeout_hit = (state == RX) && (byte_cnt != '0) && !rx_rdy &&
                       (idle_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= timeout_hit;
      if ((state != RX) || (byte_cnt == '0) || rx_rdy || timeout_hit)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// tb/tb_snn_frame_ctrl.sv - directed self-checking bench for snn_frame_ctrl (default build)
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_snn_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_d;
  logic       core_start;
  logic       core_done;
  logic [3:0] core_digit;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_rdy;
  logic [3:0] result;
  logic       busy;
  logic       overrun;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int last_we_cyc = 0;
  int last_rx_cyc = 0;
  int start_cyc = 0;
  int n_start = 0;
  int n_tx = 0;
  int n_ferr = 0;
  int prev_start;
  logic [7:0] tx_seen = 8'h00;
  logic [9:0] wr_addr[$];
  logic       wr_d[$];
  logic [7:0] exp_bytes[98];

  snn_frame_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_d      (ram_d),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_rdy     (tx_rdy),
    .result     (result),
    .busy       (busy),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ram_we) begin
      wr_addr.push_back(ram_addr);
      wr_d.push_back(ram_d);
      last_we_cyc = cyc;
    end
    if (core_start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (tx_start) begin
      n_tx++;
      tx_seen = tx_data;
    end
    if (frame_err) n_ferr++;
    if (rx_rdy) last_rx_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic check_frame(input string tag);
    int bad = 0;
    `CHK({tag, " write count"}, wr_addr.size(), 784)
    for (int i = 0; i < wr_addr.size(); i++) begin
      if (wr_addr[i] !== 10'(i) || wr_d[i] !== exp_bytes[i / 8][i % 8]) bad++;
    end
    `CHK({tag, " addr/data errors"}, bad, 0)
  endtask

  initial begin
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
    core_done = 1'b0; core_digit = 4'd0; tx_rdy = 1'b1;
    repeat (3) tick();
    `CHK("rst ram_we", ram_we, 1'b0)
    `CHK("rst ram_addr", ram_addr, 10'd0)
    `CHK("rst ram_d", ram_d, 1'b0)
    `CHK("rst core_start", core_start, 1'b0)
    `CHK("rst tx_start", tx_start, 1'b0)
    `CHK("rst tx_data", tx_data, 8'h30)
    `CHK("rst result", result, 4'd0)
    `CHK("rst busy", busy, 1'b0)
    `CHK("rst overrun", overrun, 1'b0)
    `CHK("rst frame_err", frame_err, 1'b0)
    rst_n = 1'b1;
    tick();

    // Frame 1: 98 x A5, digit 7, transmitter briefly busy after the request.
    wr_addr.delete(); wr_d.delete();
    for (int i = 0; i < 98; i++) begin
      exp_bytes[i] = 8'hA5;
      send_byte(8'hA5, 12);
    end
    check_frame("f1");
    `CHK("f1 core_start count", n_start, 1)
    `CHK("f1 unpack length", last_we_cyc - last_rx_cyc, 8)
    `CHK("f1 start after last write", start_cyc, last_we_cyc + 1)
    `CHK("f1 addr hold", ram_addr, 10'd783)
    `CHK("f1 busy waiting core", busy, 1'b1)
    core_digit = 4'd7; core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    tx_rdy = 1'b0;
    repeat (5) tick();
    `CHK("f1 busy in tx_wait", busy, 1'b1)
    tx_rdy = 1'b1;
    tick();
    `CHK("f1 busy after tx", busy, 1'b0)
    `CHK("f1 result", result, 4'd7)
    `CHK("f1 tx count", n_tx, 1)
    `CHK("f1 tx byte", tx_seen, 8'h37)
    `CHK("f1 overrun", overrun, 1'b0)

    // Frame 2: varied data, one byte dropped mid-unpack, transmitter stalled.
    wr_addr.delete(); wr_d.delete();
    for (int i = 0; i < 98; i++) begin
      exp_bytes[i] = 8'(i * 37 + 3);
      if (i == 10) begin
        rx_data = exp_bytes[i]; rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        repeat (2) tick();
        rx_data = 8'hFF; rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        repeat (12) tick();
        `CHK("f2 overrun set", overrun, 1'b1)
      end else begin
        send_byte(exp_bytes[i], 12);
      end
    end
    check_frame("f2");
    `CHK("f2 core_start count", n_start, 2)
    tx_rdy = 1'b0;
    core_digit = 4'd2; core_done = 1'b1;
    tick();
    core_done = 1'b0;
    repeat (500) tick();
    `CHK("f2 no tx while stalled", n_tx, 1)
    `CHK("f2 busy while stalled", busy, 1'b1)
    tx_rdy = 1'b1;
    tick();
    tick();
    `CHK("f2 overrun before rx", overrun, 1'b1)
    tick();
    `CHK("f2 overrun cleared", overrun, 1'b0)
    `CHK("f2 tx count", n_tx, 2)
    `CHK("f2 tx byte", tx_seen, 8'h32)
    `CHK("f2 result", result, 4'd2)
    `CHK("f2 busy after tx", busy, 1'b0)

    // Reset while unpacking byte 40, then a full frame from address 0.
    for (int i = 0; i < 40; i++) send_byte(8'h11, 12);
    rx_data = 8'h22; rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    repeat (2) tick();
    `CHK("rst mid ram_addr", ram_addr, 10'd322)
    `CHK("rst mid ram_we", ram_we, 1'b1)
    rst_n = 1'b0;
    #1;
    `CHK("async rst ram_we", ram_we, 1'b0)
    `CHK("async rst ram_addr", ram_addr, 10'd0)
    `CHK("async rst busy", busy, 1'b0)
    `CHK("async rst result", result, 4'd0)
    `CHK("async rst tx_data", tx_data, 8'h30)
    tick();
    rst_n = 1'b1;
    tick();
    wr_addr.delete(); wr_d.delete();
    prev_start = n_start;
    for (int i = 0; i < 98; i++) begin
      exp_bytes[i] = i[0] ? 8'h3C : 8'hC3;
      send_byte(exp_bytes[i], 12);
    end
    check_frame("f3");
    `CHK("f3 core_start count", n_start, prev_start + 1)
    core_digit = 4'd9; core_done = 1'b1; rx_rdy = 1'b1; rx_data = 8'h55;
    tick();
    core_done = 1'b0; rx_rdy = 1'b0;
    `CHK("f3 done beats rx result", result, 4'd9)
    `CHK("f3 tx_data latched", tx_data, 8'h39)
    `CHK("f3 overrun on collision", overrun, 1'b1)
    repeat (3) tick();
    `CHK("f3 tx count", n_tx, 3)
    `CHK("f3 tx byte", tx_seen, 8'h39)
    `CHK("f3 overrun cleared", overrun, 1'b0)
    `CHK("f3 busy after tx", busy, 1'b0)
    repeat (20) tick();
    `CHK("result persists", result, 4'd9)
    `CHK("no frame_err pulses", n_ferr, 0)

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
